// File: rtl/tick_pwm.sv
// Tick-stepped PWM / one-shot pulse generator with double-buffered period and duty.
// Shadow values move to the active set only at period boundaries, starts, or while idle.
module tick_pwm #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_tick,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_duty,
  input  logic             i_load,
  input  logic [1:0]       i_mode,
  input  logic             i_start,
  output logic             o_pwm,
  output logic             o_period_done,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_count,
  output logic             o_load_pending
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] count, count_n;
  logic [WIDTH-1:0] act_period, act_period_n;
  logic [WIDTH-1:0] act_duty, act_duty_n;
  logic [WIDTH-1:0] shd_period, shd_duty;
  logic             pending;
  logic             oneshot, oneshot_n;
  logic             pwm, pwm_n;
  logic             done, done_n;

  logic             busy;
  logic             mode_run;
  logic             start_ok;
  logic             at_end;
  logic             boundary;
  logic             transfer;

  // A programmed period of zero behaves as a period of one tick.
  function automatic logic [WIDTH-1:0] eff_period(input logic [WIDTH-1:0] p);
    return (p == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : p;
  endfunction

  assign busy     = (state != S_IDLE);
  assign mode_run = (i_mode == 2'b01) || (i_mode == 2'b10);
  assign start_ok = i_start && (busy || mode_run);
  assign at_end   = (count == eff_period(act_period) - {{(WIDTH-1){1'b0}}, 1'b1});
  assign boundary = busy && !i_start && i_tick && at_end;
  assign transfer = start_ok || boundary || (!busy && pending);

  always_comb begin
    state_n   = state;
    count_n   = count;
    oneshot_n = oneshot;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        count_n = '0;
        if (start_ok) begin
          state_n   = S_RUN;
          oneshot_n = (i_mode == 2'b10);
        end
      end
      default: begin
        if (i_start) begin
          // Restart: tick in the same cycle is dropped.
          state_n   = S_RUN;
          count_n   = '0;
          oneshot_n = (i_mode == 2'b10);
        end else if (i_tick && at_end) begin
          count_n = '0;
          done_n  = 1'b1;
          state_n = (oneshot || !mode_run) ? S_IDLE : S_RUN;
        end else begin
          if (i_tick) count_n = count + {{(WIDTH-1){1'b0}}, 1'b1};
          state_n = mode_run ? S_RUN : S_STOPPING;
        end
      end
    endcase

    act_period_n = transfer ? shd_period : act_period;
    act_duty_n   = transfer ? shd_duty   : act_duty;
    pwm_n        = (state_n != S_IDLE) && (count_n < act_duty_n);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= S_IDLE;
      count      <= '0;
      oneshot    <= 1'b0;
      pwm        <= 1'b0;
      done       <= 1'b0;
      act_period <= '1;
      act_duty   <= '0;
      shd_period <= '1;
      shd_duty   <= '0;
      pending    <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      oneshot    <= oneshot_n;
      pwm        <= pwm_n;
      done       <= done_n;
      act_period <= act_period_n;
      act_duty   <= act_duty_n;
      // A load coinciding with a transfer keeps the new values pending.
      if (i_load) begin
        shd_period <= i_period;
        shd_duty   <= i_duty;
        pending    <= 1'b1;
      end else if (transfer) begin
        pending    <= 1'b0;
      end
    end
  end

  assign o_pwm          = pwm;
  assign o_period_done  = done;
  assign o_busy         = busy;
  assign o_count        = count;
  assign o_load_pending = pending;

endmodule
